// File: rtl/text_cursor_ctrl_pkg.sv
// Shared constants, state encoding and ASCII codes for the text console writer.
// Build with SCROLL_EN defined to add the scroll-on-last-row state.
package text_pkg;
  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

`ifdef SCROLL_EN
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_CLR_LINE, ST_SCROLL} state_t;
`else
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_CLR_LINE} state_t;
`endif

  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] SP        = 8'h20;
  localparam logic [7:0] DEL_LIMIT = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= SP) && (c <= DEL_LIMIT);
  endfunction
endpackage

// File: rtl/text_cursor_ctrl_if.sv
// Key input handshake, character RAM ports and cursor position of the console writer.
// Handshake: a key transfers on a cycle where key_valid && key_ready; key_valid while key_ready is low is lost.
interface text_cursor_ctrl_if #(parameter int ADDR_W = text_pkg::ADDR_W);
  logic              key_valid;
  logic [7:0]        key_ascii;
  logic              key_ready;
  logic              busy;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W-1:0] buf_raddr;
  logic [7:0]        buf_rdata;
  logic [6:0]        cur_col;
  logic [4:0]        cur_row;

  modport master (
    input  key_valid, key_ascii, buf_rdata,
    output key_ready, busy, buf_we, buf_waddr, buf_wdata, buf_raddr, cur_col, cur_row
  );
  modport slave (
    output key_valid, key_ascii, buf_rdata,
    input  key_ready, busy, buf_we, buf_waddr, buf_wdata, buf_raddr, cur_col, cur_row
  );
endinterface

// File: rtl/text_cursor_ctrl_sweep_cnt.sv
// Loadable start/length address counter; o_last flags the final address of the sweep.
module text_sweep_cnt
  import text_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_start,
  input  logic [ADDR_W-1:0] i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end;

  // Reset loads the full-screen clear range so CLEAR can start without a load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
      r_end  <= ADDR_W'(COLS * ROWS - 1);
    end else if (i_load) begin
      r_addr <= i_start;
      r_end  <= i_start + i_len - ADDR_W'(1);
    end else if (i_en) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == r_end);
endmodule

// File: rtl/text_cursor_ctrl.sv
// Turns key events into character RAM writes: cursor, wrap, backspace, newline, clears.
// SCROLL_EN adds scrolling on a newline from the last row instead of wrapping to row 0.
module text_cursor_ctrl
  import text_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  text_cursor_ctrl_if.master        bus_if,
  output state_t                    o_state
);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COPY_N    = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_col, w_col_nxt;
  logic [4:0]        r_row, w_row_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_busy;
  logic              r_prime, w_prime_nxt;

  logic              w_cnt_load, w_cnt_en, w_cnt_last, w_do_nl;
  logic [ADDR_W-1:0] w_cnt_start, w_cnt_len, w_cnt_addr;
  logic [ADDR_W-1:0] w_row_base, w_cur_addr;

  text_sweep_cnt u_sweep (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_cnt_load),
    .i_en    (w_cnt_en),
    .i_start (w_cnt_start),
    .i_len   (w_cnt_len),
    .o_addr  (w_cnt_addr),
    .o_last  (w_cnt_last)
  );

  assign w_row_base = ADDR_W'(r_row) * ADDR_W'(COLS);
  assign w_cur_addr = w_row_base + ADDR_W'(r_col);

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_raddr_nxt = r_raddr;
    w_ready_nxt = r_ready;
    w_prime_nxt = r_prime;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_start = '0;
    w_cnt_len   = ADDR_W'(COLS);
    w_do_nl     = 1'b0;
    case (r_state)
      ST_CLEAR, ST_CLR_LINE: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = w_cnt_addr;
        w_wdata_nxt = 8'h00;
        w_cnt_en    = 1'b1;
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus_if.key_valid && r_ready) begin
          if (is_printable(bus_if.key_ascii)) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_cur_addr;
            w_wdata_nxt = bus_if.key_ascii;
            if (r_col == LAST_COL) w_do_nl = 1'b1;
            else                   w_col_nxt = r_col + 7'd1;
          end else if (bus_if.key_ascii == BS) begin
            if (r_col != 7'd0) begin
              w_col_nxt   = r_col - 7'd1;
              w_we_nxt    = 1'b1;
              w_waddr_nxt = w_cur_addr - ADDR_W'(1);
              w_wdata_nxt = 8'h00;
            end else if (r_row != 5'd0) begin
              w_row_nxt   = r_row - 5'd1;
              w_col_nxt   = LAST_COL;
              w_we_nxt    = 1'b1;
              w_waddr_nxt = w_row_base - ADDR_W'(1);
              w_wdata_nxt = 8'h00;
            end
          end else if (bus_if.key_ascii == CR || bus_if.key_ascii == LF) begin
            w_do_nl = 1'b1;
          end
        end
        if (w_do_nl) begin
          w_col_nxt   = 7'd0;
          w_ready_nxt = 1'b0;
          w_cnt_load  = 1'b1;
          if (r_row != LAST_ROW) begin
            w_row_nxt   = r_row + 5'd1;
            w_state_nxt = ST_CLR_LINE;
            w_cnt_start = w_row_base + ADDR_W'(COLS);
          end else begin
`ifdef SCROLL_EN
            w_state_nxt = ST_SCROLL;
            w_cnt_len   = COPY_N;
            w_raddr_nxt = ADDR_W'(COLS);
            w_prime_nxt = 1'b1;
`else
            w_row_nxt   = 5'd0;
            w_state_nxt = ST_CLR_LINE;
`endif
          end
        end
      end
`ifdef SCROLL_EN
      // The read address runs one cycle ahead; the first cycle only primes the RAM.
      ST_SCROLL: begin
        if (r_raddr != LAST_ADDR) w_raddr_nxt = r_raddr + ADDR_W'(1);
        if (r_prime) begin
          w_prime_nxt = 1'b0;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_cnt_addr;
          w_wdata_nxt = bus_if.buf_rdata;
          w_cnt_en    = 1'b1;
          if (w_cnt_last) begin
            w_state_nxt = ST_CLR_LINE;
            w_cnt_load  = 1'b1;
            w_cnt_start = COPY_N;
            w_raddr_nxt = '0;
          end
        end
      end
`endif
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_col   <= 7'd0;
      r_row   <= 5'd0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 8'h00;
      r_raddr <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_prime <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_raddr <= w_raddr_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= !w_ready_nxt;
      r_prime <= w_prime_nxt;
    end
  end

`ifndef SCROLL_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus_if.buf_rdata;
`endif

  assign bus_if.key_ready = r_ready;
  assign bus_if.busy      = r_busy;
  assign bus_if.buf_we    = r_we;
  assign bus_if.buf_waddr = r_waddr;
  assign bus_if.buf_wdata = r_wdata;
  assign bus_if.buf_raddr = r_raddr;
  assign bus_if.cur_col   = r_col;
  assign bus_if.cur_row   = r_row;
  assign o_state          = r_state;
endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl with a behavioural synchronous character RAM.
module tb_text_cursor_ctrl;
  import text_pkg::*;

  localparam int COPY_N = (ROWS - 1) * COLS;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_errors = 0;
  int     bad;
  logic [7:0] exp_d;
  logic [7:0] code;
  logic [7:0] mem  [0:4095];
  logic [7:0] snap [0:4095];

  text_cursor_ctrl_if bus ();

  text_cursor_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus_if  (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.buf_we) mem[bus.buf_waddr] <= bus.buf_wdata;
    bus.buf_rdata <= mem[bus.buf_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_on(input logic [7:0] c);
    bus.key_valid = 1'b1;
    bus.key_ascii = c;
  endtask

  task automatic key_off();
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Follows a sweep until key_ready returns; low0 = ready-low cycles already seen by the caller.
  task automatic run_sweep(input string tag, input int exp_start, input int exp_n,
                           input int low0, input int exp_low, input bit scroll);
    int idx = 0;
    int low = low0;
    int nbad = 0;
    logic [7:0] e;
    for (int c = 0; c < 5000; c++) begin
      tick();
      if (bus.buf_we === 1'b1) begin
        e = (scroll && idx < COPY_N) ? snap[COLS + idx] : 8'h00;
        if (bus.buf_waddr !== 12'(exp_start + idx) || bus.buf_wdata !== e) nbad++;
        idx++;
      end
      if (bus.key_ready === 1'b1) break;
      low++;
    end
    check({tag, " writes"}, idx, exp_n);
    check({tag, " bad writes"}, nbad, 0);
    check({tag, " ready low cycles"}, low, exp_low);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " we"}, bus.buf_we, 0);
    check({tag, " waddr"}, bus.buf_waddr, 0);
    check({tag, " wdata"}, bus.buf_wdata, 0);
    check({tag, " raddr"}, bus.buf_raddr, 0);
    check({tag, " col"}, bus.cur_col, 0);
    check({tag, " row"}, bus.cur_row, 0);
    check({tag, " ready"}, bus.key_ready, 0);
    check({tag, " busy"}, bus.busy, 1);
    check({tag, " state"}, dbg_state, ST_CLEAR);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'hFF;
    key_off();
    tick(); tick(); tick();
    check_reset_outputs("reset");

    rst = 1'b0;
    run_sweep("clear", 0, 2100, 1, 2100, 1'b0);
    check("clear done col", bus.cur_col, 0);
    check("clear done row", bus.cur_row, 0);
    check("clear done busy", bus.busy, 0);
    check("clear done state", dbg_state, ST_IDLE);

    // Back-to-back printable keys
    key_on(8'h41);
    tick();
    check("A we", bus.buf_we, 1);
    check("A waddr", bus.buf_waddr, 0);
    check("A wdata", bus.buf_wdata, 8'h41);
    check("A col", bus.cur_col, 1);
    check("A ready", bus.key_ready, 1);
    check("mem 2099 cleared", mem[2099], 8'h00);
    key_on(8'h42);
    tick();
    key_off();
    check("B we", bus.buf_we, 1);
    check("B waddr", bus.buf_waddr, 1);
    check("B wdata", bus.buf_wdata, 8'h42);
    check("B col", bus.cur_col, 2);

    // Printable boundaries and backspace back to column 0
    key_on(BS); tick();
    check("bs1 waddr", bus.buf_waddr, 1);
    check("bs1 col", bus.cur_col, 1);
    key_on(BS); tick();
    check("bs2 waddr", bus.buf_waddr, 0);
    check("bs2 wdata", bus.buf_wdata, 0);
    check("bs2 col", bus.cur_col, 0);
    key_on(8'h7E); tick();
    check("tilde wdata", bus.buf_wdata, 8'h7E);
    check("tilde col", bus.cur_col, 1);
    key_on(BS); tick();
    key_on(8'h07); tick();
    check("bel no write", bus.buf_we, 0);
    check("bel col", bus.cur_col, 0);
    key_on(8'h7F); tick();
    check("del no write", bus.buf_we, 0);
    key_on(8'h1F); tick();
    check("0x1f no write", bus.buf_we, 0);

    // Line wrap after 70 keys
    bad = 0;
    for (int i = 0; i < COLS; i++) begin
      code = 8'(8'h21 + i);
      key_on(code);
      tick();
      if (!(bus.buf_we === 1'b1 && bus.buf_waddr === 12'(i) && bus.buf_wdata === code)) bad++;
    end
    key_off();
    check("wrap key writes", bad, 0);
    check("wrap col", bus.cur_col, 0);
    check("wrap row", bus.cur_row, 1);
    check("wrap ready", bus.key_ready, 0);
    check("wrap busy", bus.busy, 1);
    run_sweep("wrap clr", 70, 70, 1, 70, 1'b0);

    // Backspace across the row boundary, then down to (0,0)
    key_on(BS); tick(); key_off();
    check("bs wrap we", bus.buf_we, 1);
    check("bs wrap waddr", bus.buf_waddr, 69);
    check("bs wrap wdata", bus.buf_wdata, 0);
    check("bs wrap col", bus.cur_col, 69);
    check("bs wrap row", bus.cur_row, 0);
    bad = 0;
    for (int i = 0; i < 69; i++) begin
      key_on(BS);
      tick();
      if (!(bus.buf_we === 1'b1 && bus.buf_waddr === 12'(68 - i) && bus.buf_wdata === 8'h00)) bad++;
    end
    check("bs run writes", bad, 0);
    check("bs run col", bus.cur_col, 0);
    check("mem 69 erased", mem[69], 8'h00);
    tick();
    check("bs origin no write", bus.buf_we, 0);
    check("bs origin col", bus.cur_col, 0);
    check("bs origin row", bus.cur_row, 0);
    key_off();

    // Newline, with a key offered while busy that must be dropped
    key_on(CR); tick();
    check("cr we", bus.buf_we, 0);
    check("cr row", bus.cur_row, 1);
    check("cr ready", bus.key_ready, 0);
    key_on(8'h5A); tick(); key_off();
    check("cr first clr waddr", bus.buf_waddr, 70);
    check("cr first clr wdata", bus.buf_wdata, 0);
    run_sweep("cr clr", 71, 69, 2, 70, 1'b0);
    check("dropped key col", bus.cur_col, 0);

    // Newlines down to the last row using LF and CR alternately
    for (int r = 1; r < ROWS - 1; r++) begin
      key_on((r % 2 == 0) ? LF : CR);
      tick();
      key_off();
      run_sweep("nl clr", (r + 1) * COLS, 70, 1, 70, 1'b0);
    end
    check("last row", bus.cur_row, 29);
    key_on(8'h51); tick();
    check("Q waddr", bus.buf_waddr, 2030);
    key_on(8'h52); tick();
    key_off(); tick();
    for (int a = 0; a < 4096; a++) snap[a] = mem[a];
    key_on(CR); tick(); key_off();
    check("last nl col", bus.cur_col, 0);
`ifdef SCROLL_EN
    check("scroll row", bus.cur_row, 29);
    check("scroll raddr", bus.buf_raddr, 70);
    check("scroll state", dbg_state, ST_SCROLL);
    run_sweep("scroll", 0, 2100, 1, 2101, 1'b1);
    check("scroll done row", bus.cur_row, 29);
    tick();
    bad = 0;
    for (int a = 0; a < COLS * ROWS; a++) begin
      exp_d = (a < COPY_N) ? snap[a + COLS] : 8'h00;
      if (mem[a] !== exp_d) bad++;
    end
    check("scroll ram image", bad, 0);
    check("scroll Q moved", mem[1960], 8'h51);
    check("scroll R moved", mem[1961], 8'h52);
    check("scroll last row blank", mem[2030], 8'h00);
`else
    check("wrap row0", bus.cur_row, 0);
    run_sweep("row0 clr", 0, 70, 1, 70, 1'b0);
    tick();
    check("row 29 kept Q", mem[2030], 8'h51);
    check("row 29 kept R", mem[2031], 8'h52);
`endif

    // Reset in the middle of a sweep restarts the full clear
    key_on(CR); tick(); key_off();
    tick(); tick(); tick(); tick();
    check("mid sweep busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid reset");
    rst = 1'b0;
    run_sweep("clear2", 0, 2100, 1, 2100, 1'b0);
    check("clear2 ready col", bus.cur_col, 0);
    check("clear2 ready row", bus.cur_row, 0);
    tick();
    check("clear2 erased", mem[2031], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
